cp_fifo_controller: RTL and testbench
=====================================

Name: cp_fifo_controller

Overview:
Sequences the command processor's memory-resident FIFO using the base, end, watermark and breakpoint settings from the CP register block.
- Tracks the write pointer (CPU gather-pipe line writes) and the read pointer (line fetches to the command parser).
- Maintains the read/write distance.
- Schedules one outstanding line fetch at a time.
- Raises breakpoint, overflow and underflow event pulses back to the register block.

Parameters:
LINE_BYTES, 32, bytes per FIFO line; pointer step; power of two.
ERR_W, 16, width of the error counter output.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
FIFOBase  in  32  ring start address
FIFOEnd  in  32  address of last line in ring
FIFOHighWatermark  in  32  overflow threshold (bytes)
FIFOLowWatermark  in  32  underflow threshold (bytes)
FIFOBreakpoint  in  32  read-pointer breakpoint address
FIFONewBase  in  1  pulse: reinitialise pointers
EnGPFIFO  in  1  fetch enable
EnBP  in  1  breakpoint enable
LineWrite  in  1  pulse: one line written by CPU at write pointer
FetchValid  out  1  fetch request valid
FetchAddr  out  32  line address to fetch
FetchReady  in  1  fetch request accepted
FetchDone  in  1  pulse: fetched line delivered downstream
FetchError  in  1  qualifies FetchDone: bus error
SlotFree  in  1  downstream line buffer can take a line
FIFOWritePointer  out  32  current write pointer
FIFOReadPointer  out  32  current read pointer
FIFORWDistance  out  32  bytes pending (write minus read)
IntBP  out  1  one-cycle breakpoint-hit pulse
IntFIFOverflow  out  1  one-cycle overflow pulse
IntFIFOUnderflow  out  1  one-cycle underflow pulse
StatGPReadIdle  out  1  high in IDLE with no fetch outstanding
FIFOErrors  out  ERR_W  error count

Behaviour:
Reset values:
- All pointers and FIFORWDistance are 0.
- All pulse outputs and FetchValid are 0.
- FIFOErrors is 0.
- State is IDLE.
- StatGPReadIdle is 1.

Pointer arithmetic:
- next(p) = FIFOBase when p == FIFOEnd, else p + LINE_BYTES.
- Low log2(LINE_BYTES) bits of both pointers are always 0.

Write pointer and distance:
- LineWrite: write pointer <= next(write pointer); distance += LINE_BYTES.
- Fetch completion (FetchDone, not discarded): read pointer <= next(read pointer); distance -= LINE_BYTES.
- Both events in the same cycle: both pointers advance; distance is unchanged.
- Distance arithmetic is 32-bit with no saturation.

Watermark pulses:
- IntFIFOverflow pulses on the cycle after distance moves from <= high watermark to > high watermark.
- IntFIFOUnderflow pulses on the cycle after distance moves from >= low watermark to < low watermark.
- No repeat pulse while the condition holds.

FIFONewBase:
- Both pointers <= FIFOBase; distance <= 0; watermark history cleared (no pulses result).
- Has priority over LineWrite and FetchDone in the same cycle.

State machine:
- IDLE -> BREAK when EnBP and read pointer == FIFOBreakpoint and distance != 0; IntBP pulses once on entry.
- Otherwise IDLE -> ISSUE when EnGPFIFO, distance != 0 and SlotFree.
- ISSUE: FetchValid = 1, FetchAddr = read pointer, held stable until FetchReady. On FetchReady -> WAIT.
- WAIT: on FetchDone -> IDLE. Read pointer and distance update on that FetchDone, unless a discard is pending.
- BREAK: stays while EnBP and read pointer == FIFOBreakpoint; otherwise -> IDLE. A breakpoint is not re-checked until the read pointer advances or EnBP toggles low then high.

Conditions checked in ISSUE:
- EnGPFIFO low during ISSUE before FetchReady: drop FetchValid, return to IDLE.
- FIFONewBase during ISSUE: same, return to IDLE.
- FIFONewBase while in WAIT: set a discard flag; the following FetchDone returns to IDLE without any pointer or distance update.

Reset mid-operation returns every register to its reset value, regardless of any outstanding fetch.

FetchError with FetchDone is treated as completion for sequencing purposes.

Optional Feature:
CP_FIFO_ERRORS_EN:
- When defined, FIFOErrors is a saturating counter that increments by 1 per event:
  - FetchDone with FetchError.
  - LineWrite when distance >= (FIFOEnd - FIFOBase + LINE_BYTES), i.e. the ring is already full.
  - Two events in the same cycle increment by 2.
- The counter is cleared by reset and by FIFONewBase.
- When undefined, FIFOErrors is constant 0 and no counter logic exists.

Test Plan:
1. Base=0x1000, End=0x1060, EnGPFIFO=1, SlotFree=1; 2 LineWrites -> distance 0x40; two fetches at 0x1000 then 0x1020; final read pointer 0x1040, distance 0.
2. Wrap: write pointer at 0x1060, one LineWrite -> write pointer 0x1000; fetch at 0x1060 -> read pointer 0x1000.
3. High watermark 0x40; 3 LineWrites with EnGPFIFO=0 -> exactly one IntFIFOverflow pulse, on the cycle after distance becomes 0x60. Low watermark 0x40; enable fetches -> one IntFIFOUnderflow pulse after distance drops to 0x20.
4. Breakpoint=0x1020, EnBP=1, distance 0x60 -> one fetch at 0x1000, then BREAK with a single IntBP pulse and no further FetchValid; clear EnBP -> fetch at 0x1020 resumes.
5. FIFONewBase asserted in WAIT with Base=0x2000 -> pointers 0x2000, distance 0; the late FetchDone leaves the pointers at 0x2000. LineWrite and FetchDone in the same cycle -> distance unchanged.
6. CP_FIFO_ERRORS_EN defined: FetchDone+FetchError and a full-ring LineWrite in the same cycle -> FIFOErrors +2; counter saturates at 0xFFFF. Undefined: FIFOErrors stays 0.

Source files
------------

// File: rtl/cp_fifo_controller_if.sv
// ---------------------------------------------------------------------------
// cp_fifo_controller_if
// Line-fetch channel between the CP FIFO controller and the memory/parser
// side.
//   FetchValid  fetch request valid (controller -> memory)
//   FetchAddr   line address to fetch (controller -> memory)
//   FetchReady  request accepted (memory -> controller)
//   FetchDone   pulse: fetched line delivered downstream (memory -> controller)
//   FetchError  qualifies FetchDone with a bus error (memory -> controller)
//   SlotFree    downstream line buffer can take a line (parser -> controller)
// The modport "master" is the controller side; "slave" is the memory side.
// ---------------------------------------------------------------------------
interface cp_fifo_controller_if;
   logic        FetchValid;
   logic [31:0] FetchAddr;
   logic        FetchReady;
   logic        FetchDone;
   logic        FetchError;
   logic        SlotFree;

   modport master (
      output FetchValid, FetchAddr,
      input  FetchReady, FetchDone, FetchError, SlotFree
   );

   modport slave (
      input  FetchValid, FetchAddr,
      output FetchReady, FetchDone, FetchError, SlotFree
   );
endinterface

// File: rtl/cp_fifo_controller.sv
// ---------------------------------------------------------------------------
// cp_fifo_controller
// Sequences the command processor's memory-resident ring FIFO: tracks the
// CPU write pointer and the parser read pointer, keeps the read/write
// distance, issues one line fetch at a time and pulses breakpoint /
// overflow / underflow events back to the register block.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   FIFOBase / FIFOEnd    ring start address / address of the last line
//   FIFOHigh/LowWatermark overflow / underflow thresholds in bytes
//   FIFOBreakpoint        read-pointer breakpoint address
//   FIFONewBase           pulse: reload both pointers from FIFOBase
//   EnGPFIFO / EnBP       fetch enable / breakpoint enable
//   LineWrite             pulse: CPU wrote one line at the write pointer
//   fetch                 line-fetch channel (cp_fifo_controller_if.master)
//   FIFOWritePointer, FIFOReadPointer, FIFORWDistance   ring status
//   IntBP, IntFIFOverflow, IntFIFOUnderflow             one-cycle events
//   StatGPReadIdle        idle with no fetch outstanding
//   FIFOErrors            error count
//
// Build option: define CP_FIFO_ERRORS_EN to get a saturating error counter
// on FIFOErrors (bus errors and writes into a full ring). Without it
// FIFOErrors is tied to zero.
// ---------------------------------------------------------------------------
module cp_fifo_controller #(
   parameter int LINE_BYTES = 32,
   parameter int ERR_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          FIFOBase,
   input  logic [31:0]          FIFOEnd,
   input  logic [31:0]          FIFOHighWatermark,
   input  logic [31:0]          FIFOLowWatermark,
   input  logic [31:0]          FIFOBreakpoint,
   input  logic                 FIFONewBase,
   input  logic                 EnGPFIFO,
   input  logic                 EnBP,
   input  logic                 LineWrite,
   cp_fifo_controller_if.master fetch,
   output logic [31:0]          FIFOWritePointer,
   output logic [31:0]          FIFOReadPointer,
   output logic [31:0]          FIFORWDistance,
   output logic                 IntBP,
   output logic                 IntFIFOverflow,
   output logic                 IntFIFOUnderflow,
   output logic                 StatGPReadIdle,
   output logic [ERR_W-1:0]     FIFOErrors
);

   localparam logic [31:0] LINE_STEP  = 32'(LINE_BYTES);
   localparam logic [31:0] ALIGN_MASK = ~(LINE_STEP - 32'd1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_BREAK} state_t;

   state_t      state;
   logic        discard;      // a FIFONewBase hit while a fetch was in flight
   logic        bp_block;     // breakpoint already taken at this read pointer
   logic [31:0] dist_prev;    // distance one cycle ago, for edge detection

   logic [31:0] base_al;
   logic [31:0] end_al;
   logic        wr_adv;
   logic        rd_adv;
   logic        bp_match;

   function automatic logic [31:0] next_ptr(input logic [31:0] p,
                                            input logic [31:0] base,
                                            input logic [31:0] last);
      return (p == last) ? base : p + LINE_STEP;
   endfunction

   // Keep pointers line aligned even if software writes stray low bits.
   assign base_al  = FIFOBase & ALIGN_MASK;
   assign end_al   = FIFOEnd  & ALIGN_MASK;

   // FIFONewBase overrides both pointer movements in the same cycle.
   assign wr_adv   = LineWrite && !FIFONewBase;
   assign rd_adv   = (state == ST_WAIT) && fetch.FetchDone && !discard && !FIFONewBase;
   assign bp_match = EnBP && (FIFOReadPointer == FIFOBreakpoint);

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         discard          <= 1'b0;
         bp_block         <= 1'b0;
         dist_prev        <= '0;
         FIFOWritePointer <= '0;
         FIFOReadPointer  <= '0;
         FIFORWDistance   <= '0;
         IntBP            <= 1'b0;
         IntFIFOverflow   <= 1'b0;
         IntFIFOUnderflow <= 1'b0;
         StatGPReadIdle   <= 1'b1;
         fetch.FetchValid <= 1'b0;
         fetch.FetchAddr  <= '0;
      end else begin
         IntBP <= 1'b0;

         // Pointers, distance and watermark edge detection
         if (FIFONewBase) begin
            FIFOWritePointer <= base_al;
            FIFOReadPointer  <= base_al;
            FIFORWDistance   <= '0;
            // Matching dist_prev to the new distance suppresses any edge.
            dist_prev        <= '0;
            IntFIFOverflow   <= 1'b0;
            IntFIFOUnderflow <= 1'b0;
         end else begin
            if (wr_adv) FIFOWritePointer <= next_ptr(FIFOWritePointer, base_al, end_al);
            if (rd_adv) FIFOReadPointer  <= next_ptr(FIFOReadPointer, base_al, end_al);
            case ({wr_adv, rd_adv})
               2'b10:   FIFORWDistance <= FIFORWDistance + LINE_STEP;
               2'b01:   FIFORWDistance <= FIFORWDistance - LINE_STEP;
               default: FIFORWDistance <= FIFORWDistance;
            endcase
            dist_prev        <= FIFORWDistance;
            IntFIFOverflow   <= (FIFORWDistance > FIFOHighWatermark) &&
                                !(dist_prev > FIFOHighWatermark);
            IntFIFOUnderflow <= (FIFORWDistance < FIFOLowWatermark) &&
                                !(dist_prev < FIFOLowWatermark);
         end

         // Re-arm the breakpoint once the read pointer moves or EnBP drops.
         if (FIFONewBase || rd_adv || !EnBP) bp_block <= 1'b0;

         // Fetch sequencing
         case (state)
            ST_IDLE: begin
               if (!FIFONewBase && bp_match && !bp_block && FIFORWDistance != '0) begin
                  state          <= ST_BREAK;
                  IntBP          <= 1'b1;
                  bp_block       <= 1'b1;
                  StatGPReadIdle <= 1'b0;
               end else if (!FIFONewBase && EnGPFIFO && FIFORWDistance != '0 && fetch.SlotFree) begin
                  state            <= ST_ISSUE;
                  fetch.FetchValid <= 1'b1;
                  fetch.FetchAddr  <= FIFOReadPointer;
                  StatGPReadIdle   <= 1'b0;
               end
            end
            ST_ISSUE: begin
               // An accepted request must be followed to completion; a
               // simultaneous FIFONewBase only marks its data for discard.
               if (fetch.FetchReady) begin
                  state            <= ST_WAIT;
                  fetch.FetchValid <= 1'b0;
                  if (FIFONewBase) discard <= 1'b1;
               end else if (FIFONewBase || !EnGPFIFO) begin
                  state            <= ST_IDLE;
                  fetch.FetchValid <= 1'b0;
                  StatGPReadIdle   <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (fetch.FetchDone) begin
                  // FetchError still completes the transaction.
                  state          <= ST_IDLE;
                  discard        <= 1'b0;
                  StatGPReadIdle <= 1'b1;
               end else if (FIFONewBase) begin
                  discard <= 1'b1;
               end
            end
            ST_BREAK: begin
               if (!bp_match) begin
                  state          <= ST_IDLE;
                  StatGPReadIdle <= 1'b1;
               end
            end
            default: begin
               state          <= ST_IDLE;
               StatGPReadIdle <= 1'b1;
            end
         endcase
      end
   end

`ifdef CP_FIFO_ERRORS_EN
   logic [31:0] ring_bytes;
   logic        ring_full;
   logic [1:0]  err_inc;

   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                input logic [1:0]       inc);
      logic [ERR_W:0] sum;
      sum = {1'b0, acc} + {{(ERR_W-1){1'b0}}, inc};
      return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
   endfunction

   assign ring_bytes = end_al - base_al + LINE_STEP;
   assign ring_full  = FIFORWDistance >= ring_bytes;
   assign err_inc    = {1'b0, fetch.FetchDone && fetch.FetchError} +
                       {1'b0, LineWrite && ring_full};

   always_ff @(posedge clk) begin
      if (reset || FIFONewBase) FIFOErrors <= '0;
      else                      FIFOErrors <= sat_add(FIFOErrors, err_inc);
   end
`else
   logic unused_fetch_error;
   assign unused_fetch_error = fetch.FetchError;
   assign FIFOErrors         = '0;
`endif

endmodule

// File: tb/tb_cp_fifo_controller.sv
module tb_cp_fifo_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] FIFOBase, FIFOEnd, FIFOHighWatermark, FIFOLowWatermark, FIFOBreakpoint;
   logic        FIFONewBase, EnGPFIFO, EnBP, LineWrite;
   logic [31:0] FIFOWritePointer, FIFOReadPointer, FIFORWDistance;
   logic        IntBP, IntFIFOverflow, IntFIFOUnderflow, StatGPReadIdle;
   logic [15:0] FIFOErrors;

   int          checks = 0;
   int          errors = 0;
   int          bp_cnt = 0;
   int          unf_cnt = 0;
   logic [31:0] unf_dist = '0;

   cp_fifo_controller_if fif();

   cp_fifo_controller #(.LINE_BYTES(32), .ERR_W(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .FIFOBase          (FIFOBase),
      .FIFOEnd           (FIFOEnd),
      .FIFOHighWatermark (FIFOHighWatermark),
      .FIFOLowWatermark  (FIFOLowWatermark),
      .FIFOBreakpoint    (FIFOBreakpoint),
      .FIFONewBase       (FIFONewBase),
      .EnGPFIFO          (EnGPFIFO),
      .EnBP              (EnBP),
      .LineWrite         (LineWrite),
      .fetch             (fif),
      .FIFOWritePointer  (FIFOWritePointer),
      .FIFOReadPointer   (FIFOReadPointer),
      .FIFORWDistance    (FIFORWDistance),
      .IntBP             (IntBP),
      .IntFIFOverflow    (IntFIFOverflow),
      .IntFIFOUnderflow  (IntFIFOUnderflow),
      .StatGPReadIdle    (StatGPReadIdle),
      .FIFOErrors        (FIFOErrors)
   );

   // Event counters for pulses that land while a task is busy serving fetches.
   always @(negedge clk) begin
      if (IntBP) bp_cnt++;
      if (IntFIFOUnderflow) begin
         unf_cnt++;
         unf_dist = FIFORWDistance;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      FIFOBase          = 32'h1000;
      FIFOEnd           = 32'h1060;
      FIFOHighWatermark = 32'hFFFF_FFFF;
      FIFOLowWatermark  = 32'h0;
      FIFOBreakpoint    = 32'h0;
      FIFONewBase       = 1'b0;
      EnGPFIFO          = 1'b0;
      EnBP              = 1'b0;
      LineWrite         = 1'b0;
      fif.FetchReady    = 1'b0;
      fif.FetchDone     = 1'b0;
      fif.FetchError    = 1'b0;
      fif.SlotFree      = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic new_base(input logic [31:0] b, input logic [31:0] e);
      FIFOBase    = b;
      FIFOEnd     = e;
      FIFONewBase = 1'b1;
      tick(1);
      FIFONewBase = 1'b0;
   endtask

   task automatic write_lines(input int n);
      LineWrite = 1'b1;
      tick(n);
      LineWrite = 1'b0;
   endtask

   task automatic wait_valid(output bit seen, output logic [31:0] addr);
      seen = 1'b0;
      addr = '0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (fif.FetchValid === 1'b1) begin
            seen = 1'b1;
            addr = fif.FetchAddr;
            break;
         end
      end
   endtask

   task automatic serve_fetch(output bit seen, output logic [31:0] addr);
      wait_valid(seen, addr);
      if (seen) begin
         fif.FetchReady = 1'b1;
         tick(1);
         fif.FetchReady = 1'b0;
         fif.FetchDone  = 1'b1;
         tick(1);
         fif.FetchDone  = 1'b0;
      end
   endtask

   task automatic test_reset();
      bit          seen;
      logic [31:0] addr;
      idle_inputs();
      reset = 1'b1;
      tick(2);
      checks++; if (FIFOWritePointer !== 32'h0) begin errors++; $display("FAIL reset_wp got %h want %h", FIFOWritePointer, 32'h0); end
      checks++; if (FIFOReadPointer !== 32'h0) begin errors++; $display("FAIL reset_rp got %h want %h", FIFOReadPointer, 32'h0); end
      checks++; if (FIFORWDistance !== 32'h0) begin errors++; $display("FAIL reset_dist got %h want %h", FIFORWDistance, 32'h0); end
      checks++; if ({fif.FetchValid, IntBP, IntFIFOverflow, IntFIFOUnderflow} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {fif.FetchValid, IntBP, IntFIFOverflow, IntFIFOUnderflow}); end
      checks++; if (StatGPReadIdle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", StatGPReadIdle); end
      checks++; if (FIFOErrors !== 16'h0) begin errors++; $display("FAIL reset_errors got %h want 0", FIFOErrors); end
      reset = 1'b0;
      tick(1);
      // Reset while a fetch is outstanding.
      new_base(32'h1000, 32'h1060);
      write_lines(1);
      EnGPFIFO = 1'b1;
      wait_valid(seen, addr);
      fif.FetchReady = 1'b1;
      tick(1);
      fif.FetchReady = 1'b0;
      EnGPFIFO = 1'b0;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      fif.FetchDone = 1'b1;
      tick(1);
      fif.FetchDone = 1'b0;
      tick(1);
      checks++; if ({FIFOWritePointer, FIFOReadPointer, FIFORWDistance} !== 96'h0) begin errors++; $display("FAIL midreset_ptrs got %h %h %h want 0 0 0", FIFOWritePointer, FIFOReadPointer, FIFORWDistance); end
      checks++; if (StatGPReadIdle !== 1'b1 || fif.FetchValid !== 1'b0) begin errors++; $display("FAIL midreset_state got idle=%b valid=%b want 1 0", StatGPReadIdle, fif.FetchValid); end
   endtask

   task automatic test_basic_fetch();
      bit          seen;
      logic [31:0] addr;
      do_reset();
      new_base(32'h1000, 32'h1060);
      checks++; if (FIFOReadPointer !== 32'h1000) begin errors++; $display("FAIL newbase_rp got %h want %h", FIFOReadPointer, 32'h1000); end
      write_lines(2);
      checks++; if (FIFOWritePointer !== 32'h1040) begin errors++; $display("FAIL basic_wp got %h want %h", FIFOWritePointer, 32'h1040); end
      checks++; if (FIFORWDistance !== 32'h40) begin errors++; $display("FAIL basic_dist got %h want %h", FIFORWDistance, 32'h40); end
      EnGPFIFO = 1'b1;
      serve_fetch(seen, addr);
      checks++; if (!seen || addr !== 32'h1000) begin errors++; $display("FAIL basic_fetch0 got seen=%b addr=%h want 1 %h", seen, addr, 32'h1000); end
      serve_fetch(seen, addr);
      checks++; if (!seen || addr !== 32'h1020) begin errors++; $display("FAIL basic_fetch1 got seen=%b addr=%h want 1 %h", seen, addr, 32'h1020); end
      tick(2);
      checks++; if (FIFOReadPointer !== 32'h1040) begin errors++; $display("FAIL basic_rp got %h want %h", FIFOReadPointer, 32'h1040); end
      checks++; if (FIFORWDistance !== 32'h0) begin errors++; $display("FAIL basic_dist_end got %h want 0", FIFORWDistance); end
      checks++; if (StatGPReadIdle !== 1'b1 || fif.FetchValid !== 1'b0) begin errors++; $display("FAIL basic_idle got idle=%b valid=%b want 1 0", StatGPReadIdle, fif.FetchValid); end
      EnGPFIFO = 1'b0;
   endtask

   task automatic test_wrap();
      bit          seen;
      logic [31:0] addr;
      do_reset();
      new_base(32'h1000, 32'h1060);
      write_lines(3);
      checks++; if (FIFOWritePointer !== 32'h1060) begin errors++; $display("FAIL wrap_wp_pre got %h want %h", FIFOWritePointer, 32'h1060); end
      write_lines(1);
      checks++; if (FIFOWritePointer !== 32'h1000) begin errors++; $display("FAIL wrap_wp got %h want %h", FIFOWritePointer, 32'h1000); end
      checks++; if (FIFORWDistance !== 32'h80) begin errors++; $display("FAIL wrap_dist got %h want %h", FIFORWDistance, 32'h80); end
      EnGPFIFO = 1'b1;
      for (int i = 0; i < 3; i++) serve_fetch(seen, addr);
      checks++; if (!seen || addr !== 32'h1040) begin errors++; $display("FAIL wrap_fetch2 got seen=%b addr=%h want 1 %h", seen, addr, 32'h1040); end
      serve_fetch(seen, addr);
      checks++; if (!seen || addr !== 32'h1060) begin errors++; $display("FAIL wrap_fetch3 got seen=%b addr=%h want 1 %h", seen, addr, 32'h1060); end
      checks++; if (FIFOReadPointer !== 32'h1000) begin errors++; $display("FAIL wrap_rp got %h want %h", FIFOReadPointer, 32'h1000); end
      checks++; if (FIFORWDistance !== 32'h0) begin errors++; $display("FAIL wrap_dist_end got %h want 0", FIFORWDistance); end
      EnGPFIFO = 1'b0;
   endtask

   task automatic test_watermarks();
      bit          seen;
      logic [31:0] addr;
      int          ovf_n = 0;
      int          ovf_at = -1;
      int          d60_at = -1;
      int          unf_base;
      do_reset();
      FIFOHighWatermark = 32'h40;
      FIFOLowWatermark  = 32'h40;
      new_base(32'h1000, 32'h1060);
      LineWrite = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (FIFORWDistance === 32'h60 && d60_at < 0) d60_at = i;
         if (IntFIFOverflow === 1'b1) begin
            ovf_n++;
            if (ovf_at < 0) ovf_at = i;
         end
         if (i == 2) LineWrite = 1'b0;
      end
      checks++; if (ovf_n != 1) begin errors++; $display("FAIL ovf_count got %0d want 1", ovf_n); end
      checks++; if (d60_at < 0 || ovf_at != d60_at + 1) begin errors++; $display("FAIL ovf_timing got pulse@%0d dist60@%0d want pulse one cycle later", ovf_at, d60_at); end
      unf_base = unf_cnt;
      EnGPFIFO = 1'b1;
      for (int i = 0; i < 3; i++) serve_fetch(seen, addr);
      tick(3);
      checks++; if (unf_cnt - unf_base != 1) begin errors++; $display("FAIL unf_count got %0d want 1", unf_cnt - unf_base); end
      checks++; if (unf_dist !== 32'h20) begin errors++; $display("FAIL unf_dist got %h want %h", unf_dist, 32'h20); end
      checks++; if (FIFORWDistance !== 32'h0) begin errors++; $display("FAIL wm_drain got %h want 0", FIFORWDistance); end
      EnGPFIFO = 1'b0;
   endtask

   task automatic test_breakpoint();
      bit          seen;
      logic [31:0] addr;
      bit          fv_seen = 1'b0;
      int          bp_base;
      do_reset();
      new_base(32'h1000, 32'h1060);
      FIFOBreakpoint = 32'h1020;
      EnBP = 1'b1;
      write_lines(3);
      bp_base = bp_cnt;
      EnGPFIFO = 1'b1;
      serve_fetch(seen, addr);
      checks++; if (!seen || addr !== 32'h1000) begin errors++; $display("FAIL bp_fetch0 got seen=%b addr=%h want 1 %h", seen, addr, 32'h1000); end
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (fif.FetchValid === 1'b1) fv_seen = 1'b1;
      end
      checks++; if (bp_cnt - bp_base != 1) begin errors++; $display("FAIL bp_pulses got %0d want 1", bp_cnt - bp_base); end
      checks++; if (fv_seen !== 1'b0) begin errors++; $display("FAIL bp_stall got valid=%b want 0", fv_seen); end
      checks++; if (FIFOReadPointer !== 32'h1020 || StatGPReadIdle !== 1'b0) begin errors++; $display("FAIL bp_hold got rp=%h idle=%b want %h 0", FIFOReadPointer, StatGPReadIdle, 32'h1020); end
      EnBP = 1'b0;
      serve_fetch(seen, addr);
      checks++; if (!seen || addr !== 32'h1020) begin errors++; $display("FAIL bp_resume got seen=%b addr=%h want 1 %h", seen, addr, 32'h1020); end
      EnGPFIFO = 1'b0;
      tick(2);
   endtask

   task automatic test_issue_cancel();
      bit          seen;
      logic [31:0] addr;
      do_reset();
      new_base(32'h1000, 32'h1060);
      write_lines(1);
      EnGPFIFO = 1'b1;
      wait_valid(seen, addr);
      checks++; if (!seen || addr !== 32'h1000) begin errors++; $display("FAIL cancel_issue got seen=%b addr=%h want 1 %h", seen, addr, 32'h1000); end
      EnGPFIFO = 1'b0;
      tick(1);
      checks++; if (fif.FetchValid !== 1'b0 || StatGPReadIdle !== 1'b1) begin errors++; $display("FAIL cancel_drop got valid=%b idle=%b want 0 1", fif.FetchValid, StatGPReadIdle); end
      checks++; if (FIFOReadPointer !== 32'h1000 || FIFORWDistance !== 32'h20) begin errors++; $display("FAIL cancel_ptrs got rp=%h dist=%h want %h %h", FIFOReadPointer, FIFORWDistance, 32'h1000, 32'h20); end
   endtask

   task automatic test_newbase_wait();
      bit          seen;
      logic [31:0] addr;
      do_reset();
      new_base(32'h1000, 32'h1060);
      write_lines(2);
      EnGPFIFO = 1'b1;
      wait_valid(seen, addr);
      checks++; if (!seen || addr !== 32'h1000) begin errors++; $display("FAIL nb_issue got seen=%b addr=%h want 1 %h", seen, addr, 32'h1000); end
      fif.FetchReady = 1'b1;
      tick(1);
      fif.FetchReady = 1'b0;
      new_base(32'h2000, 32'h2060);
      checks++; if ({FIFOWritePointer, FIFOReadPointer, FIFORWDistance} !== {32'h2000, 32'h2000, 32'h0}) begin errors++; $display("FAIL nb_reload got %h %h %h want 2000 2000 0", FIFOWritePointer, FIFOReadPointer, FIFORWDistance); end
      fif.FetchDone = 1'b1;
      tick(1);
      fif.FetchDone = 1'b0;
      tick(2);
      checks++; if ({FIFOWritePointer, FIFOReadPointer, FIFORWDistance} !== {32'h2000, 32'h2000, 32'h0}) begin errors++; $display("FAIL nb_discard got %h %h %h want 2000 2000 0", FIFOWritePointer, FIFOReadPointer, FIFORWDistance); end
      checks++; if (StatGPReadIdle !== 1'b1 || fif.FetchValid !== 1'b0) begin errors++; $display("FAIL nb_idle got idle=%b valid=%b want 1 0", StatGPReadIdle, fif.FetchValid); end
      EnGPFIFO = 1'b0;
      write_lines(2);
      EnGPFIFO = 1'b1;
      wait_valid(seen, addr);
      checks++; if (!seen || addr !== 32'h2000) begin errors++; $display("FAIL both_issue got seen=%b addr=%h want 1 %h", seen, addr, 32'h2000); end
      fif.FetchReady = 1'b1;
      tick(1);
      fif.FetchReady = 1'b0;
      EnGPFIFO = 1'b0;
      fif.FetchDone = 1'b1;
      LineWrite = 1'b1;
      tick(1);
      fif.FetchDone = 1'b0;
      LineWrite = 1'b0;
      checks++; if (FIFORWDistance !== 32'h40) begin errors++; $display("FAIL both_dist got %h want %h", FIFORWDistance, 32'h40); end
      checks++; if (FIFOWritePointer !== 32'h2060 || FIFOReadPointer !== 32'h2020) begin errors++; $display("FAIL both_ptrs got wp=%h rp=%h want %h %h", FIFOWritePointer, FIFOReadPointer, 32'h2060, 32'h2020); end
   endtask

   task automatic test_errors();
      do_reset();
      new_base(32'h1000, 32'h1060);
      write_lines(4);
      checks++; if (FIFORWDistance !== 32'h80) begin errors++; $display("FAIL err_full got %h want %h", FIFORWDistance, 32'h80); end
      LineWrite      = 1'b1;
      fif.FetchDone  = 1'b1;
      fif.FetchError = 1'b1;
      tick(1);
`ifdef CP_FIFO_ERRORS_EN
      checks++; if (FIFOErrors !== 16'd2) begin errors++; $display("FAIL err_double got %h want %h", FIFOErrors, 16'd2); end
      tick(32767);
      checks++; if (FIFOErrors !== 16'hFFFF) begin errors++; $display("FAIL err_sat got %h want %h", FIFOErrors, 16'hFFFF); end
      LineWrite      = 1'b0;
      fif.FetchDone  = 1'b0;
      fif.FetchError = 1'b0;
      new_base(32'h1000, 32'h1060);
      checks++; if (FIFOErrors !== 16'h0) begin errors++; $display("FAIL err_clear got %h want 0", FIFOErrors); end
`else
      tick(3);
      LineWrite      = 1'b0;
      fif.FetchDone  = 1'b0;
      fif.FetchError = 1'b0;
      checks++; if (FIFOErrors !== 16'h0) begin errors++; $display("FAIL err_off got %h want 0", FIFOErrors); end
`endif
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_basic_fetch();
      test_wrap();
      test_watermarks();
      test_breakpoint();
      test_issue_cancel();
      test_newbase_wait();
      test_errors();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
